// File: rtl/sr_pkg.sv
// Shared types and helpers for the set/reset command generator.
`timescale 1ns/1ps
package sr_pkg;

  // Command FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 32'd1;
    while ((64'd1 << w) <= 64'(max_val)) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Synchroniser, debounce filter and rising-edge detector for one raw input.
`timescale 1ns/1ps
module sr_debounce
  import sr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned DB_CYCLES   = 32'd4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_dly_q, db_dly_d;
  logic                   lvl_s;

  // Shift the raw input through the synchroniser and filter the result
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    lvl_s    = sync_q[SYNC_STAGES-1];
    db_d     = db_q;
    cnt_d    = '0;
    db_dly_d = db_q;
    if (lvl_s != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 32'd1)) begin
        // Level has differed long enough: accept it
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers for synchroniser, counter and debounced levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
    end
  end

  assign rise = db_q & ~db_dly_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncy request lines into exclusive, spaced one-cycle s/r commands.
`timescale 1ns/1ps
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 32'd2,
  parameter int unsigned DB_CYCLES    = 32'd4,
  parameter int unsigned GAP_CYCLES   = 32'd2,
  parameter bit          CLR_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned GW = cnt_width(GAP_CYCLES);

  logic          set_rise_s, clr_rise_s;
  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          set_pend_q, set_pend_d;
  logic          clr_pend_q, clr_pend_d;
  logic          s_q, s_d, r_q, r_d;
  logic          busy_q, busy_d;
  logic          conflict_q, conflict_d;
  logic          take_s;

  sr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .reset(reset), .din(set_in), .rise(set_rise_s)
  );

  sr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .din(clr_in), .rise(clr_rise_s)
  );

  // FSM state, gap counter, pending flags and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      set_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      set_pend_q <= set_pend_d;
      clr_pend_q <= clr_pend_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  // Next-state logic: IDLE issues, PULSE lasts one cycle, GAP enforces spacing
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (set_pend_q || clr_pend_q) begin
          state_d = PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        if (GAP_CYCLES > 32'd0) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES - 32'd1);
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == GW'(0)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Output decode: choose the command, consume pending flags, derive busy
  always_comb begin
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    take_s     = (state_q == IDLE);
    if (take_s && set_pend_q && clr_pend_q) begin
      // Both requested: one wins, the other is dropped and flagged
      conflict_d = 1'b1;
      if (CLR_PRIORITY) begin
        r_d = 1'b1;
      end else begin
        s_d = 1'b1;
      end
    end else if (take_s) begin
      s_d = set_pend_q;
      r_d = clr_pend_q;
    end else begin
      s_d = 1'b0;
      r_d = 1'b0;
    end
    // Every pending flag seen in IDLE is consumed; a new rise re-arms it
    set_pend_d = (set_pend_q & ~take_s) | set_rise_s;
    clr_pend_d = (clr_pend_q & ~take_s) | clr_rise_s;
    busy_d     = (state_d != IDLE) | set_pend_d | clr_pend_d;
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule
